// File: rtl/multicycle_main_control.sv
// Multi-cycle main control FSM for the RV64I lab datapath: fetch, decode,
// execute, memory and writeback sequencing plus the ALUOp/Funct pair for ALU_Control.
module multicycle_main_control (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] instr,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    input  logic        zero,
    output logic        imem_req,
    output logic [1:0]  ALUOp,
    output logic [3:0]  Funct,
    output logic        ALUSrc,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemtoReg,
    output logic        PCWrite,
    output logic        PCSrc,
    output logic        busy,
    output logic        done,
    output logic        illegal
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CL_ILLEGAL = 3'd0,
        CL_RALU    = 3'd1,
        CL_IALU    = 3'd2,
        CL_LOAD    = 3'd3,
        CL_STORE   = 3'd4,
        CL_BRANCH  = 3'd5
    } op_class_t;

    function automatic op_class_t classify(input logic [6:0] opcode);
        op_class_t cls;
        case (opcode)
            7'b0110011: cls = CL_RALU;
            7'b0010011: cls = CL_IALU;
            7'b0000011: cls = CL_LOAD;
            7'b0100011: cls = CL_STORE;
            7'b1100011: cls = CL_BRANCH;
            default:    cls = CL_ILLEGAL;
        endcase
        return cls;
    endfunction

    function automatic logic [1:0] alu_op_of(input op_class_t cls);
        logic [1:0] op;
        case (cls)
            CL_RALU, CL_IALU:  op = 2'b10;
            CL_BRANCH:         op = 2'b01;
            default:           op = 2'b00;
        endcase
        return op;
    endfunction

    // For I-type only the shift-right pair uses bit 30; other immediates must not leak it.
    function automatic logic [3:0] funct_of(input op_class_t cls, input logic bit30,
                                            input logic [2:0] funct3);
        logic [3:0] f;
        if ((cls == CL_IALU) && (funct3 != 3'b101)) begin
            f = {1'b0, funct3};
        end else begin
            f = {bit30, funct3};
        end
        return f;
    endfunction

    state_t      state_r;
    state_t      next_state_s;
    logic [31:0] ir_r;
    logic [1:0]  alu_op_r;
    logic [3:0]  funct_r;
    op_class_t   cls_s;
    logic        ir_unused_s;

    assign cls_s       = classify(ir_r[6:0]);
    assign ir_unused_s = ^{ir_r[31], ir_r[29:15], ir_r[11:7]};
    assign ALUOp       = alu_op_r;
    assign Funct       = funct_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Instruction register, captured on the fetch acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_r <= 32'd0;
        end else if ((state_r == ST_FETCH) && imem_ack) begin
            ir_r <= instr;
        end
    end

    // ALUOp/Funct register, loaded only on the DECODE->EXEC transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op_r <= 2'b00;
            funct_r  <= 4'b0000;
        end else if ((state_r == ST_DECODE) && (cls_s != CL_ILLEGAL)) begin
            alu_op_r <= alu_op_of(cls_s);
            funct_r  <= funct_of(cls_s, ir_r[30], ir_r[14:12]);
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ST_FETCH;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    next_state_s = ST_DECODE;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (cls_s == CL_ILLEGAL) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (cls_s)
                    CL_RALU, CL_IALU:   next_state_s = ST_WB;
                    CL_LOAD, CL_STORE:  next_state_s = ST_MEM;
                    default:            next_state_s = ST_IDLE;
                endcase
            end
            ST_MEM: begin
                if (!dmem_ack) begin
                    next_state_s = ST_MEM;
                end else if (cls_s == CL_STORE) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_WB;
                end
            end
            ST_WB:   next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Datapath strobes decoded from state and the held instruction.
    always_comb begin
        imem_req = 1'b0;
        ALUSrc   = 1'b0;
        RegWrite = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemtoReg = 1'b0;
        PCWrite  = 1'b0;
        PCSrc    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        illegal  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy = 1'b0;
            end
            ST_FETCH: begin
                busy     = 1'b1;
                imem_req = 1'b1;
            end
            ST_DECODE: begin
                busy    = 1'b1;
                illegal = (cls_s == CL_ILLEGAL);
            end
            ST_EXEC: begin
                busy   = 1'b1;
                ALUSrc = (cls_s == CL_IALU) || (cls_s == CL_LOAD) || (cls_s == CL_STORE);
                if (cls_s == CL_BRANCH) begin
                    PCWrite = 1'b1;
                    PCSrc   = zero;
                    done    = 1'b1;
                end else begin
                    PCWrite = 1'b0;
                    PCSrc   = 1'b0;
                    done    = 1'b0;
                end
            end
            ST_MEM: begin
                busy = 1'b1;
                if (cls_s == CL_STORE) begin
                    MemWrite = 1'b1;
                    PCWrite  = dmem_ack;
                    done     = dmem_ack;
                end else begin
                    MemRead  = 1'b1;
                end
            end
            ST_WB: begin
                busy     = 1'b1;
                RegWrite = 1'b1;
                MemtoReg = (cls_s == CL_LOAD);
                PCWrite  = 1'b1;
                done     = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_main_control.sv
// Scoreboard bench for multicycle_main_control: stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares on every done/illegal pulse.
module tb_multicycle_main_control;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] instr = 32'd0;
    logic        imem_ack = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        zero = 1'b0;
    logic        imem_req, ALUSrc, RegWrite, MemRead, MemWrite, MemtoReg;
    logic        PCWrite, PCSrc, busy, done, illegal;
    logic [1:0]  ALUOp;
    logic [3:0]  Funct;

    multicycle_main_control dut (
        .clk(clk), .rst_n(rst_n), .start(start), .instr(instr),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .zero(zero),
        .imem_req(imem_req), .ALUOp(ALUOp), .Funct(Funct), .ALUSrc(ALUSrc),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemtoReg(MemtoReg), .PCWrite(PCWrite), .PCSrc(PCSrc),
        .busy(busy), .done(done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic       ill;
        logic [1:0] aop;
        logic [3:0] fn;
        int         rw;
        int         m2r;
        int         pcw;
        logic       pcs;
        int         mr;
        int         mw;
        int         req;
        int         bsy;
        int         asrc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;
    int   ev_cnt = 0;
    int   iwait = 0;
    int   dwait = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Memory responders: acknowledge after iwait/dwait cycles of an active request.
    initial begin : responder
        int ic;
        int dc;
        ic = 0;
        dc = 0;
        forever begin
            @(posedge clk);
            #1;
            if (imem_req) begin
                imem_ack = (ic == iwait);
                ic++;
            end else begin
                imem_ack = 1'b0;
                ic = 0;
            end
            if (MemRead || MemWrite) begin
                dmem_ack = (dc == dwait);
                dc++;
            end else begin
                dmem_ack = 1'b0;
                dc = 0;
            end
        end
    end

    // Monitor: accumulate strobe activity, compare against the scoreboard on each terminal pulse.
    initial begin : monitor
        int   bc, rq, mr, mw, rwc, m2c, pwc, asc;
        exp_t e;
        bc = 0; rq = 0; mr = 0; mw = 0; rwc = 0; m2c = 0; pwc = 0; asc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bc = 0; rq = 0; mr = 0; mw = 0; rwc = 0; m2c = 0; pwc = 0; asc = 0;
            end else begin
                bc  += int'(busy);
                rq  += int'(imem_req);
                mr  += int'(MemRead);
                mw  += int'(MemWrite);
                rwc += int'(RegWrite);
                m2c += int'(MemtoReg);
                pwc += int'(PCWrite);
                asc += int'(ALUSrc);
                if (done || illegal) begin
                    ev_cnt++;
                    if (q.size() == 0) begin
                        n_vec++;
                        n_miss++;
                        $display("FAIL unexpected_event: got done=%0b illegal=%0b, expected none (cycle %0d)",
                                 done, illegal, cyc);
                    end else begin
                        e = q.pop_front();
                        chk("event_cycle", cyc, e.cyc);
                        chk("illegal", illegal, e.ill);
                        chk("done", done, !e.ill);
                        chk("pcsrc", PCSrc, e.pcs);
                        chk("pcwrite_cycles", pwc, e.pcw);
                        chk("regwrite_cycles", rwc, e.rw);
                        chk("memtoreg_cycles", m2c, e.m2r);
                        chk("memread_cycles", mr, e.mr);
                        chk("memwrite_cycles", mw, e.mw);
                        chk("imem_req_cycles", rq, e.req);
                        chk("busy_cycles", bc, e.bsy);
                        chk("alusrc_cycles", asc, e.asrc);
                        if (!e.ill) begin
                            chk("aluop", ALUOp, e.aop);
                            chk("funct", Funct, e.fn);
                        end
                    end
                    bc = 0; rq = 0; mr = 0; mw = 0; rwc = 0; m2c = 0; pwc = 0; asc = 0;
                end
            end
        end
    end

    task automatic run(input logic [31:0] ins, input int iw, input int dw, input logic z,
                       input int lat, input logic ill, input logic [1:0] aop, input logic [3:0] fn,
                       input int rw, input int m2r, input logic pcs, input int mr, input int mw,
                       input int asrc, input logic start_in_exec);
        exp_t e;
        int   ev0;
        int   k;
        @(posedge clk);
        #1;
        instr = ins;
        iwait = iw;
        dwait = dw;
        zero  = z;
        chk("idle_busy", busy, 1'b0);
        e.cyc = cyc + lat; e.ill = ill; e.aop = aop; e.fn = fn; e.rw = rw; e.m2r = m2r;
        e.pcw = ill ? 0 : 1; e.pcs = pcs; e.mr = mr; e.mw = mw; e.req = 1 + iw;
        e.bsy = lat; e.asrc = asrc;
        q.push_back(e);
        ev0   = ev_cnt;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (start_in_exec) begin
            repeat (2) @(posedge clk);
            #1;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        k = 0;
        while ((ev_cnt == ev0) && (k < 60)) begin
            @(posedge clk);
            k++;
        end
        if (ev_cnt == ev0) begin
            n_vec++;
            n_miss++;
            $display("FAIL timeout: instr 0x%08h gave no done/illegal within 60 cycles", ins);
            q.delete();
        end
        if (start_in_exec) begin
            repeat (2) begin
                #1;
                chk("start_ignored_busy", busy, 1'b0);
                @(posedge clk);
            end
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int k;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {imem_req, ALUOp, Funct, ALUSrc, RegWrite, MemRead, MemWrite,
                              MemtoReg, PCWrite, PCSrc, busy, done, illegal}, 17'd0);
        rst_n = 1'b1;

        //   instr          iw dw z  lat ill aop    funct   rw m2r pcs mr mw asrc sie
        run(32'h002081B3, 0, 0, 1'b0, 4, 1'b0, 2'b10, 4'b0000, 1, 0, 1'b0, 0, 0, 0, 1'b0); // add
        run(32'h402081B3, 2, 0, 1'b0, 6, 1'b0, 2'b10, 4'b1000, 1, 0, 1'b0, 0, 0, 0, 1'b0); // sub
        run(32'h4020D1B3, 0, 0, 1'b0, 4, 1'b0, 2'b10, 4'b1101, 1, 0, 1'b0, 0, 0, 0, 1'b0); // sra
        run(32'h4050D093, 0, 0, 1'b0, 4, 1'b0, 2'b10, 4'b1101, 1, 0, 1'b0, 0, 0, 1, 1'b0); // srai
        run(32'h00508093, 0, 0, 1'b0, 4, 1'b0, 2'b10, 4'b0000, 1, 0, 1'b0, 0, 0, 1, 1'b0); // addi
        run(32'h40008093, 0, 0, 1'b0, 4, 1'b0, 2'b10, 4'b0000, 1, 0, 1'b0, 0, 0, 1, 1'b0); // addi imm[10]=1
        run(32'h0080B283, 0, 3, 1'b0, 8, 1'b0, 2'b00, 4'b0011, 1, 1, 1'b0, 4, 0, 1, 1'b0); // ld, slow
        run(32'h0080B283, 0, 0, 1'b0, 5, 1'b0, 2'b00, 4'b0011, 1, 1, 1'b0, 1, 0, 1, 1'b0); // ld
        run(32'h0050B423, 0, 0, 1'b0, 4, 1'b0, 2'b00, 4'b0011, 0, 0, 1'b0, 0, 1, 1, 1'b0); // sd
        run(32'h0050B423, 0, 2, 1'b0, 6, 1'b0, 2'b00, 4'b0011, 0, 0, 1'b0, 0, 3, 1, 1'b0); // sd, slow
        run(32'h00208063, 0, 0, 1'b1, 3, 1'b0, 2'b01, 4'b0000, 0, 0, 1'b1, 0, 0, 0, 1'b0); // beq taken
        run(32'h00208063, 2, 0, 1'b0, 5, 1'b0, 2'b01, 4'b0000, 0, 0, 1'b0, 0, 0, 0, 1'b0); // beq not taken
        run(32'hFFFFFFFF, 5, 0, 1'b0, 7, 1'b1, 2'b00, 4'b0000, 0, 0, 1'b0, 0, 0, 0, 1'b0); // illegal, slow fetch
        run(32'h00000000, 0, 0, 1'b0, 2, 1'b1, 2'b00, 4'b0000, 0, 0, 1'b0, 0, 0, 0, 1'b0); // illegal
        run(32'h002081B3, 0, 0, 1'b0, 4, 1'b0, 2'b10, 4'b0000, 1, 0, 1'b0, 0, 0, 0, 1'b1); // start in EXEC

        // Reset asserted in the middle of a stalled load.
        @(posedge clk);
        #1;
        instr = 32'h0080B283;
        iwait = 0;
        dwait = 20;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 0;
        while (!MemRead && (k < 20)) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("load_reached_mem", MemRead, 1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {imem_req, ALUOp, Funct, ALUSrc, RegWrite, MemRead, MemWrite,
                                    MemtoReg, PCWrite, PCSrc, busy, done, illegal}, 17'd0);
        #12;
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("post_reset_quiet", {RegWrite, done, MemRead, busy}, 4'd0);
        end

        chk("scoreboard_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
